// File: rtl/display_pkg.sv
// Shared types and constants for the display mode controller.
package display_pkg;

    // Width of the idle-seconds counter used by the auto-return feature.
    localparam int IDLE_W = 8;

    // The encoding doubles as the select code for the downstream source selector.
    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SEC   = 2'b01,
        MODE_SW    = 2'b10,
        MODE_BLANK = 2'b11
    } mode_t;

    // Mode-key stepping: CLOCK -> SECONDS -> STOPWATCH -> CLOCK; BLANK exits to CLOCK.
    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_CLOCK: next_mode = MODE_SEC;
            MODE_SEC:   next_mode = MODE_SW;
            default:    next_mode = MODE_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchronizer plus falling-edge detector for one active-low key.
// A press is only recognised after the synchronized key has been seen released
// at least once since reset, so a key held through reset never fires.
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] live;
    logic       armed;

    // Synchronize the key, remember its last sampled level, and arm after a real release.
    // NOTE: reset is sampled inside the clocked block (synchronous), and all state uses <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            live  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
            live  <= {live[0], 1'b1};
            // live[1] marks sync2 as carrying a post-reset sample rather than its reset value.
            if (live[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign press = armed & prev & ~sync2;

endmodule

// File: rtl/display_mode_controller.sv
// Display mode FSM: CLOCK / SECONDS / STOPWATCH / BLANK driven by two keys.
// Optional feature macro: DISPLAY_AUTO_RETURN_EN compiles in the idle counter
// that returns SECONDS to CLOCK after TIMEOUT_S seconds without a press.
import display_pkg::*;

module display_mode_controller #(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_mode_n,
    input  logic       key_blank_n,
    output logic [1:0] select,
    output logic       enable,
    output logic       mode_changed,
    output logic       timeout
);

    mode_t state;
    mode_t state_nxt;
    logic  mode_press;
    logic  blank_press;

    key_edge_detect u_key_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (mode_press)
    );

    key_edge_detect u_key_blank (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_blank_n),
        .press (blank_press)
    );

`ifdef DISPLAY_AUTO_RETURN_EN
    localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT_S);

    logic [IDLE_W-1:0] idle_cnt;
    logic              fire;
`else
    // Tick and timeout setting only matter when auto-return is built in.
    logic unused_cfg;
    assign unused_cfg = ^{tick_1hz, IDLE_W'(TIMEOUT_S)};
`endif

    // Next-state decode: blank beats mode, and any press beats auto-return.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
`ifdef DISPLAY_AUTO_RETURN_EN
        fire      = 1'b0;
`endif
        if (blank_press) begin
            state_nxt = (state == MODE_BLANK) ? MODE_CLOCK : MODE_BLANK;
        end else if (mode_press) begin
            state_nxt = next_mode(state);
        end
`ifdef DISPLAY_AUTO_RETURN_EN
        else if (state == MODE_SEC && idle_cnt == TIMEOUT_CNT) begin
            state_nxt = MODE_CLOCK;
            fire      = 1'b1;
        end
`endif
    end

    // State register with registered enable and change pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= MODE_CLOCK;
            enable       <= 1'b1;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_nxt;
            enable       <= (state_nxt != MODE_BLANK);
            mode_changed <= (state_nxt != state);
        end
    end

    assign select = state;

`ifdef DISPLAY_AUTO_RETURN_EN
    // Idle-seconds counter: counts only in SECONDS, cleared by presses and state changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= fire;
            if (mode_press || blank_press || state_nxt != state || state != MODE_SEC) begin
                idle_cnt <= '0;
            end else if (tick_1hz) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_display_mode_controller.sv
// Directed self-checking bench for display_mode_controller.
// Covers both builds: the auto-return section follows DISPLAY_AUTO_RETURN_EN.
module tb_display_mode_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic       key_mode_n;
    logic       key_blank_n;
    logic [1:0] select;
    logic       enable;
    logic       mode_changed;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int mc_cnt   = 0;
    int to_cnt   = 0;

    display_mode_controller #(.TIMEOUT_S(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .key_mode_n   (key_mode_n),
        .key_blank_n  (key_blank_n),
        .select       (select),
        .enable       (enable),
        .mode_changed (mode_changed),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Count output pulses, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mode_changed === 1'b1) mc_cnt++;
        if (timeout === 1'b1) to_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press and release keys; the state updates on the third edge after the fall.
    task automatic press(input bit m, input bit b);
        key_mode_n  = ~m;
        key_blank_n = ~b;
        step(3);
        key_mode_n  = 1'b1;
        key_blank_n = 1'b1;
        step(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            step(1);
        end
    endtask

    int mc_base;
    int exp_sel [3] = '{1, 2, 0};

    initial begin
        rst_n       = 1'b0;
        tick_1hz    = 1'b0;
        key_mode_n  = 1'b1;
        key_blank_n = 1'b1;
        step(3);
        check("rst_select", select, 0);
        check("rst_enable", enable, 1);
        check("rst_mode_changed", mode_changed, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        step(5);
        check("post_rst_select", select, 0);

        // Three mode presses: 00 -> 01 -> 10 -> 00 with exact 3-cycle latency.
        mc_base = mc_cnt;
        for (int i = 0; i < 3; i++) begin
            key_mode_n = 1'b0;
            step(2);
            check("latency_early_select", select, (i == 0) ? 0 : exp_sel[i-1]);
            step(1);
            check("latency_select", select, exp_sel[i]);
            check("latency_pulse", mode_changed, 1);
            step(1);
            check("pulse_one_cycle", mode_changed, 0);
            key_mode_n = 1'b1;
            step(4);
        end
        check("mode_cycle_pulses", mc_cnt - mc_base, 3);

        // STOPWATCH -> BLANK -> CLOCK.
        press(1, 0);
        press(1, 0);
        check("to_stopwatch", select, 2);
        press(0, 1);
        check("blank_select", select, 3);
        check("blank_enable", enable, 0);
        press(1, 0);
        check("blank_mode_select", select, 0);
        check("blank_mode_enable", enable, 1);

        // Blank toggles BLANK back to CLOCK.
        press(0, 1);
        press(0, 1);
        check("blank_blank_select", select, 0);

        // Simultaneous mode and blank from CLOCK: blank wins, one pulse.
        mc_base = mc_cnt;
        press(1, 1);
        check("both_select", select, 3);
        check("both_enable", enable, 0);
        check("both_pulses", mc_cnt - mc_base, 1);
        press(0, 1);
        check("both_back", select, 0);

        // Key release produces no pulse and no change.
        mc_base = mc_cnt;
        key_mode_n = 1'b0;
        step(3);
        check("held_select", select, 1);
        step(10);
        key_mode_n = 1'b1;
        step(6);
        check("release_no_change", mc_cnt - mc_base, 1);

`ifdef DISPLAY_AUTO_RETURN_EN
        // In SECONDS: 10 ticks with no press return to CLOCK with one timeout pulse.
        to_cnt  = 0;
        mc_base = mc_cnt;
        ticks(9);
        check("to_not_yet_select", select, 1);
        check("to_not_yet_count", to_cnt, 0);
        ticks(1);
        check("to_select", select, 0);
        check("to_pulse", timeout, 1);
        step(1);
        check("to_pulse_one_cycle", timeout, 0);
        check("to_count", to_cnt, 1);
        check("to_changed", mc_cnt - mc_base, 1);

        // 9 ticks, a press, then 9 ticks anywhere: no timeout.
        press(1, 0);
        check("to2_sec", select, 1);
        ticks(9);
        press(1, 0);
        check("to2_sw", select, 2);
        ticks(9);
        check("to2_sw_hold", select, 2);
        press(1, 0);
        press(1, 0);
        check("to2_sec_again", select, 1);
        ticks(9);
        check("to2_no_timeout_select", select, 1);
        check("to2_no_timeout_count", to_cnt, 1);
        ticks(1);
        check("to2_final_select", select, 0);
        check("to2_final_count", to_cnt, 2);
        press(1, 0);
`else
        // Without auto-return SECONDS persists indefinitely.
        to_cnt = 0;
        ticks(300);
        check("noar_select", select, 1);
        check("noar_timeout", timeout, 0);
        check("noar_count", to_cnt, 0);
`endif

        // Reset with mode key held low, then keep it low: no press is seen.
        check("pre_rst_select", select, 1);
        key_mode_n = 1'b0;
        rst_n      = 1'b0;
        step(3);
        check("midpress_rst_select", select, 0);
        mc_base = mc_cnt;
        rst_n   = 1'b1;
        step(20);
        check("midpress_select", select, 0);
        check("midpress_pulses", mc_cnt - mc_base, 0);
        key_mode_n = 1'b1;
        step(5);
        press(1, 0);
        check("midpress_rearm", select, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
